// File: rtl/ipv4_dl_pkg.sv
// Shared definitions for the IPv4 deadlock report unit.
// Holds the FSM state encoding, the width helpers used to size index,
// length and counter fields, and the report counter width.
package ipv4_dl_pkg;

  localparam int unsigned REPORT_COUNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ORIGIN = 3'd1,
    ST_TRACE  = 3'd2,
    ST_REPORT = 3'd3,
    ST_REARM  = 3'd4
  } dl_state_e;

  // Bits needed to index n items (at least 1).
  function automatic int unsigned IPV4_DL_IDX_W(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to hold a count 0..n (at least 1).
  function automatic int unsigned IPV4_DL_LEN_W(input int unsigned n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/ipv4_dl_bitvec_util.sv
// Bit-vector helper: lowest-set-index priority encode and popcount.
// Ports:
//   vec       in   W      vector under inspection
//   lsb_idx_c out  IDX_W  index of the lowest set bit (0 when vec == 0)
//   any_c     out  1      vec != 0
//   popcnt_c  out  LEN_W  number of set bits in vec
module ipv4_dl_bitvec_util #(
  parameter int unsigned W     = 4,
  parameter int unsigned IDX_W = 2,
  parameter int unsigned LEN_W = 3
) (
  input  logic [W-1:0]     vec,
  output logic [IDX_W-1:0] lsb_idx_c,
  output logic             any_c,
  output logic [LEN_W-1:0] popcnt_c
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    lsb_idx_c = '0;
    popcnt_c  = '0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (vec[i]) lsb_idx_c = IDX_W'(i);
      popcnt_c = popcnt_c + LEN_W'(vec[i]);
    end
    any_c = |vec;
  end

endmodule

// File: rtl/ipv4_top_hls_deadlock_report_unit.sv
// Deadlock report unit: picks an origin process from the detect flags,
// follows the circulating token to collect the processes on the wait
// cycle, then presents one report per deadlock over a valid/ready port.
// Ports:
//   clock, reset      clock, asynchronous active-low reset
//   dl_detect_in      per-process deadlock detect flags
//   token_in_vec      per-process token-held flags
//   origin            one-hot origin strobe (one cycle)
//   token_clear       one-cycle broadcast token clear at trace end
//   dl_detect_out     high while a deadlock is being traced/reported
//   report_*          report payload with valid/ready handshake
//   report_count      saturating count of accepted reports
// Build option: define IPV4_DL_TRACE_TIMEOUT_EN to add the trace watchdog
// that ends a trace after TIMEOUT_CYCLES-1 cycles.
module ipv4_top_hls_deadlock_report_unit
  import ipv4_dl_pkg::*;
#(
  parameter int unsigned PROC_NUM       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [PROC_NUM-1:0]                dl_detect_in,
  input  logic [PROC_NUM-1:0]                token_in_vec,
  output logic [PROC_NUM-1:0]                origin,
  output logic                               token_clear,
  output logic                               dl_detect_out,
  output logic                               report_vld,
  input  logic                               report_rdy,
  output logic [IPV4_DL_IDX_W(PROC_NUM)-1:0] report_origin,
  output logic [PROC_NUM-1:0]                report_cycle,
  output logic [IPV4_DL_LEN_W(PROC_NUM)-1:0] report_len,
  output logic                               report_err,
  output logic [REPORT_COUNT_W-1:0]          report_count
);

  localparam int unsigned IDX_W = IPV4_DL_IDX_W(PROC_NUM);
  localparam int unsigned LEN_W = IPV4_DL_LEN_W(PROC_NUM);
`ifdef IPV4_DL_TRACE_TIMEOUT_EN
  localparam int unsigned CNT_W = IPV4_DL_IDX_W(TIMEOUT_CYCLES);
`else
  localparam int unsigned CNT_W = 1;
`endif

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..65535");
  end

  dl_state_e                 state_q, state_d;
  logic [IDX_W-1:0]          origin_idx_q, origin_idx_d;
  logic [PROC_NUM-1:0]       visited_q, visited_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [PROC_NUM-1:0]       origin_q, origin_d;
  logic                      token_clear_q, token_clear_d;
  logic                      dl_detect_out_q, dl_detect_out_d;
  logic                      report_vld_q, report_vld_d;
  logic [IDX_W-1:0]          report_origin_q, report_origin_d;
  logic [PROC_NUM-1:0]       report_cycle_q, report_cycle_d;
  logic [LEN_W-1:0]          report_len_q, report_len_d;
  logic                      report_err_q, report_err_d;
  logic [REPORT_COUNT_W-1:0] report_count_q, report_count_d;

  logic [PROC_NUM-1:0] visited_nx_c;
  logic [IDX_W-1:0]    det_idx_c;
  logic                det_any_c;
  logic [LEN_W-1:0]    vis_len_c;
  logic [LEN_W-1:0]    unused_det_len;
  logic [IDX_W-1:0]    unused_vis_idx;
  logic                unused_vis_any;
  logic                trace_exit_c;
  logic                trace_err_c;

  // Cycle set including this cycle's token holders; popcount gives report_len.
  assign visited_nx_c = visited_q | token_in_vec;

  ipv4_dl_bitvec_util #(.W(PROC_NUM), .IDX_W(IDX_W), .LEN_W(LEN_W)) u_det_util (
    .vec       (dl_detect_in),
    .lsb_idx_c (det_idx_c),
    .any_c     (det_any_c),
    .popcnt_c  (unused_det_len)
  );

  ipv4_dl_bitvec_util #(.W(PROC_NUM), .IDX_W(IDX_W), .LEN_W(LEN_W)) u_vis_util (
    .vec       (visited_nx_c),
    .lsb_idx_c (unused_vis_idx),
    .any_c     (unused_vis_any),
    .popcnt_c  (vis_len_c)
  );

  // Trace exit decision: token return beats token loss beats watchdog.
  always_comb begin
    trace_exit_c = 1'b0;
    trace_err_c  = 1'b0;
    if (cnt_q != '0 && token_in_vec[origin_idx_q]) begin
      trace_exit_c = 1'b1;
    end else if (cnt_q != '0 && token_in_vec == '0) begin
      trace_exit_c = 1'b1;
      trace_err_c  = 1'b1;
    end
`ifdef IPV4_DL_TRACE_TIMEOUT_EN
    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      trace_exit_c = 1'b1;
      trace_err_c  = 1'b1;
    end
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d         = state_q;
    origin_idx_d    = origin_idx_q;
    visited_d       = visited_q;
    cnt_d           = cnt_q;
    origin_d        = '0;
    token_clear_d   = 1'b0;
    report_vld_d    = report_vld_q;
    report_origin_d = report_origin_q;
    report_cycle_d  = report_cycle_q;
    report_len_d    = report_len_q;
    report_err_d    = report_err_q;
    report_count_d  = report_count_q;

    case (state_q)
      ST_IDLE: begin
        if (det_any_c) begin
          origin_idx_d = det_idx_c;
          origin_d     = PROC_NUM'(1) << det_idx_c;
          state_d      = ST_ORIGIN;
        end
      end
      ST_ORIGIN: begin
        visited_d = PROC_NUM'(1) << origin_idx_q;
        cnt_d     = '0;
        state_d   = ST_TRACE;
      end
      ST_TRACE: begin
        visited_d = visited_nx_c;
`ifdef IPV4_DL_TRACE_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`else
        // Without the watchdog the counter only records "not first cycle".
        cnt_d = CNT_W'(1);
`endif
        if (trace_exit_c) begin
          token_clear_d   = 1'b1;
          report_vld_d    = 1'b1;
          report_origin_d = origin_idx_q;
          report_cycle_d  = visited_nx_c;
          report_len_d    = vis_len_c;
          report_err_d    = trace_err_c;
          state_d         = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (report_rdy) begin
          report_vld_d = 1'b0;
          if (report_count_q != '1) report_count_d = report_count_q + REPORT_COUNT_W'(1);
          state_d = ST_REARM;
        end
      end
      ST_REARM: begin
        // Wait for the detect flags to clear so one deadlock is reported once.
        if (!det_any_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    dl_detect_out_d = (state_d == ST_ORIGIN) || (state_d == ST_TRACE) || (state_d == ST_REPORT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      origin_idx_q    <= '0;
      visited_q       <= '0;
      cnt_q           <= '0;
      origin_q        <= '0;
      token_clear_q   <= 1'b0;
      dl_detect_out_q <= 1'b0;
      report_vld_q    <= 1'b0;
      report_origin_q <= '0;
      report_cycle_q  <= '0;
      report_len_q    <= '0;
      report_err_q    <= 1'b0;
      report_count_q  <= '0;
    end else begin
      state_q         <= state_d;
      origin_idx_q    <= origin_idx_d;
      visited_q       <= visited_d;
      cnt_q           <= cnt_d;
      origin_q        <= origin_d;
      token_clear_q   <= token_clear_d;
      dl_detect_out_q <= dl_detect_out_d;
      report_vld_q    <= report_vld_d;
      report_origin_q <= report_origin_d;
      report_cycle_q  <= report_cycle_d;
      report_len_q    <= report_len_d;
      report_err_q    <= report_err_d;
      report_count_q  <= report_count_d;
    end
  end

  assign origin        = origin_q;
  assign token_clear   = token_clear_q;
  assign dl_detect_out = dl_detect_out_q;
  assign report_vld    = report_vld_q;
  assign report_origin = report_origin_q;
  assign report_cycle  = report_cycle_q;
  assign report_len    = report_len_q;
  assign report_err    = report_err_q;
  assign report_count  = report_count_q;

endmodule

// File: doc/ipv4_top_hls_deadlock_report_unit.md
IPV4_TOP_HLS_DEADLOCK_REPORT_UNIT -- requirements
Module: ipv4_top_hls_deadlock_report_unit

Interface
REQ-001 Parameter PROC_NUM, default 4: number of per-process detection units observed.
REQ-002 Parameter TIMEOUT_CYCLES, default 64: trace watchdog limit in cycles; legal range 2..65535.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port list (name, direction, width, meaning):
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- dl_detect_in  in  PROC_NUM  per-process deadlock detect flags.
- token_in_vec  in  PROC_NUM  per-process "token held" flags, OR of each unit's token_out_vec.
- origin  out  PROC_NUM  one-hot origin strobe to detection units.
- token_clear  out  1  broadcast token clear.
- dl_detect_out  out  1  global deadlock-under-trace flag.
- report_vld  out  1  report valid.
- report_rdy  in  1  report accept.
- report_origin  out  clog2(PROC_NUM)  origin process index.
- report_cycle  out  PROC_NUM  bitmap of processes on the traced cycle.
- report_len  out  clog2(PROC_NUM+1)  popcount of report_cycle.
- report_err  out  1  trace ended by token loss or timeout.
- report_count  out  16  saturating count of completed reports.

Function
REQ-005 The FSM SHALL have the states IDLE, ORIGIN, TRACE, REPORT and REARM.
REQ-006 IDLE: if dl_detect_in != 0, latch origin_idx = lowest set index and go to ORIGIN; otherwise stay in IDLE.
REQ-007 ORIGIN: origin SHALL equal 1<<origin_idx for exactly one cycle; set visited = 1<<origin_idx; clear the trace counter; go to TRACE.
REQ-008 dl_detect_out SHALL be 1 in ORIGIN, TRACE and REPORT, and 0 in IDLE and REARM.
REQ-009 TRACE, each cycle: visited |= token_in_vec; the trace counter increments.
REQ-010 TRACE exit on token return: if token_in_vec[origin_idx]=1 and the counter is >0, pulse token_clear for 1 cycle, set report_err=0 and go to REPORT.
REQ-011 TRACE exit on token loss: if token_in_vec==0 and the counter is >0, pulse token_clear, set report_err=1 and go to REPORT.
REQ-012 If both REQ-010 and REQ-011 conditions could apply in the same cycle, REQ-010 SHALL take priority.
REQ-013 REPORT: report_vld=1; report_* outputs SHALL be stable until the cycle of report_vld&report_rdy, then go to REARM; report_count increments and saturates at 0xFFFF.
REQ-014 report_len SHALL equal the popcount of report_cycle, registered on entry to REPORT (zero additional latency visible to the consumer).
REQ-015 REARM: stay while dl_detect_in != 0; return to IDLE on the first cycle it is 0, so the same deadlock is never reported twice.
REQ-016 report_rdy is ignored outside REPORT; dl_detect_in changes during ORIGIN/TRACE/REPORT are ignored.

Reset
REQ-017 On reset assertion, all outputs SHALL be 0 and the state SHALL be IDLE, asynchronously.
REQ-018 Reset mid-trace SHALL abandon the trace with no token_clear pulse; the first post-reset cycle is IDLE.

Configuration
REQ-019 With IPV4_DL_TRACE_TIMEOUT_EN defined: if TRACE reaches counter == TIMEOUT_CYCLES-1 without exiting, pulse token_clear, set report_err=1 and go to REPORT.
REQ-020 Without IPV4_DL_TRACE_TIMEOUT_EN: no watchdog exists, and TRACE exits only via REQ-010/REQ-011; the counter is kept only for the >0 qualifier, 1 bit wide.

Structure
REQ-021 The FSM state enum, the IPV4_DL_* width helpers and the report_count width constant SHALL live in the shared package ipv4_dl_pkg.
REQ-022 Lowest-set-index priority encode and popcount SHALL be one sub-module, ipv4_dl_bitvec_util, instantiated twice.

Verification
REQ-023 The bench SHALL cover the following directed scenarios, PROC_NUM=4:
- dl_detect_in=0100 → origin=0100 for 1 cycle; then token_in_vec 1000,0010,0100 → token_clear 1 cycle, report_cycle=1110, report_len=3, report_origin=2, report_err=0.
- dl_detect_in=0110 in the same cycle → origin_idx=1.
- After ORIGIN, token_in_vec=0000 → report_err=1, report_cycle=origin bit only, report_len=1.
- report_rdy held 0 for 10 cycles → report outputs stable; on handshake report_count 0→1; dl_detect_in held 1 → no new origin until it drops for ≥1 cycle.
- IPV4_DL_TRACE_TIMEOUT_EN, TIMEOUT_CYCLES=8, token circulating without reaching origin → token_clear at trace cycle 7, report_err=1.
- Reset asserted during TRACE → all outputs 0 immediately, no token_clear, state IDLE.
